// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
// Serializer that follows the stereo audio low-pass filter and drives an
// external I2S or left-justified DAC. Both 16-bit channels are captured
// together once per 32-bit frame. The frame rate is set only by the clock
// divider and does not depend on the filter's update rate.
//
// Parameters:
//   CLK_DIV      clk cycles per bclk half-period (1..255)
//
// Build option:
//   I2S_LJ_FORMAT_EN  when defined, the word select follows the left-justified
//                     format (lrclk changes together with the MSB). When not
//                     defined, standard I2S word select is used (lrclk leads the
//                     MSB by one bclk).
//
// Ports:
//   clk          system clock (the filter's clock)
//   reset        asynchronous, active-high reset
//   ena          run enable; low clears everything synchronously
//   audio_left   16-bit two's-complement left sample
//   audio_right  16-bit two's-complement right sample
//   i2s_bclk     serial bit clock, period 2*CLK_DIV clk
//   i2s_lrclk    word select, 0 = left, 1 = right
//   i2s_data     serial data, MSB first, changes on falling bclk
//   sample_req   one-clk pulse when a new left/right pair is captured
module audio_i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        sample_req
);

  logic [7:0]  div_cnt;
  logic [7:0]  div_last;
  logic [4:0]  bit_cnt;
  logic [4:0]  bit_nxt;
  logic [31:0] frame;
  logic        wrap;
  logic        fe;

  assign div_last = 8'(CLK_DIV - 1);
  assign wrap     = (div_cnt == div_last);
  // A divider wrap while bclk is high drives bclk low: that is the only
  // moment the frame state is allowed to move.
  assign fe       = wrap & i2s_bclk;
  assign bit_nxt  = bit_cnt + 5'd1;

  // Word select for the bit position n that is about to be driven.
  function automatic logic word_select(input logic [4:0] n);
`ifdef I2S_LJ_FORMAT_EN
    // Left-justified: lrclk switches together with the MSB of each word.
    return (n >= 5'd16);
`else
    // I2S: lrclk is ((n+1) mod 32)[4], i.e. high for n = 15..30, so it
    // changes one bclk ahead of each MSB.
    return (n >= 5'd15) && (n != 5'd31);
`endif
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= 8'd0;
      i2s_bclk   <= 1'b0;
      bit_cnt    <= 5'd31;
      frame      <= 32'd0;
      i2s_lrclk  <= 1'b0;
      i2s_data   <= 1'b0;
      sample_req <= 1'b0;
    end else if (!ena) begin
      // Dropping ena abandons the frame in flight; restart is identical to a
      // reset release.
      div_cnt    <= 8'd0;
      i2s_bclk   <= 1'b0;
      bit_cnt    <= 5'd31;
      frame      <= 32'd0;
      i2s_lrclk  <= 1'b0;
      i2s_data   <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      div_cnt    <= wrap ? 8'd0 : div_cnt + 8'd1;
      if (wrap) begin
        i2s_bclk <= ~i2s_bclk;
      end
      if (fe) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= word_select(bit_nxt);
        if (bit_nxt == 5'd0) begin
          // Frame boundary: both channels latched in the same edge so the
          // pair is always coherent; the MSB goes straight to the pin since
          // the frame register only becomes valid after this edge.
          frame      <= {audio_left, audio_right};
          i2s_data   <= audio_left[15];
          sample_req <= 1'b1;
        end else begin
          i2s_data <= frame[5'd31 - bit_nxt];
        end
      end
    end
  end

endmodule
